// File: rtl/design_mux_pkg.sv
// Shared types and default sizing for the sequenced design-select multiplexer.
package design_mux_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    QUIESCE,
    RESET_NEW
  } mux_state_t;

  localparam int DEF_NUM_DES   = 64;
  localparam int DEF_IO_W      = 12;
  localparam int DEF_GUARD_CYC = 4;
  localparam int DEF_RST_CYC   = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/design_mux_fsm.sv
// Switchover sequencer: ACTIVE -> QUIESCE (outgoing held idle) -> RESET_NEW (incoming held in reset).
module design_mux_fsm
  import design_mux_pkg::*;
#(
  parameter int NUM_DES   = DEF_NUM_DES,
  parameter int SEL_W     = $clog2(NUM_DES),
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] des_sel,
  input  logic             sel_lock,
  output mux_state_t       state,
  output logic             switch_start,
  output logic [SEL_W-1:0] active_sel,
  output logic             switch_busy,
  output logic             sel_err
);

  localparam int CNT_W = $clog2(max_int(GUARD_CYC, RST_CYC) + 1);
  localparam logic [SEL_W:0] NUM_DES_W = (SEL_W + 1)'(NUM_DES);

  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] pend_sel;
  logic             sel_valid;

  assign sel_valid    = {1'b0, des_sel} < NUM_DES_W;
  assign switch_start = (state == ACTIVE) && sel_valid && (des_sel != active_sel) && !sel_lock;

  // The counter is reloaded on every state entry and counts down to zero.
  always_ff @(posedge clock) begin
    sel_err <= !sel_valid;
    if (reset) begin
      state       <= ACTIVE;
      cnt         <= '0;
      pend_sel    <= '0;
      active_sel  <= sel_valid ? des_sel : '0;
      switch_busy <= 1'b0;
    end else begin
      unique case (state)
        ACTIVE: begin
          if (switch_start) begin
            pend_sel    <= des_sel;
            state       <= QUIESCE;
            cnt         <= CNT_W'(GUARD_CYC - 1);
            switch_busy <= 1'b1;
          end
        end
        QUIESCE: begin
          if (cnt == '0) begin
            active_sel <= pend_sel;
            state      <= RESET_NEW;
            cnt        <= CNT_W'(RST_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESET_NEW: begin
          if (cnt == '0) begin
            state       <= ACTIVE;
            switch_busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state       <= ACTIVE;
          switch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/design_mux_seq.sv
// Sequenced design-select mux for the shared IO pads.
// Optional MUX_SEL_LOCK_EN adds a sel_lock input that blocks new switch requests.
module design_mux_seq
  import design_mux_pkg::*;
#(
  parameter int NUM_DES   = DEF_NUM_DES,
  parameter int IO_W      = DEF_IO_W,
  parameter int SEL_W     = $clog2(NUM_DES),
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IO_W-1:0]               io_in,
  output logic [IO_W-1:0]               io_out,
  input  logic [SEL_W-1:0]              des_sel,
  input  logic                          hold_if_not_sel,
  output logic [NUM_DES-1:0][IO_W-1:0]  des_io_in,
  output logic [NUM_DES-1:0]            des_reset,
  input  logic [NUM_DES-1:0][IO_W-1:0]  des_io_out,
  output logic [SEL_W-1:0]              active_sel,
  output logic                          switch_busy,
  output logic                          sel_err
`ifdef MUX_SEL_LOCK_EN
  ,
  input  logic                          sel_lock
`endif
);

  mux_state_t state;
  logic       switch_start;
  logic       lock;

`ifdef MUX_SEL_LOCK_EN
  assign lock = sel_lock;
`else
  assign lock = 1'b0;
`endif

  design_mux_fsm #(
    .NUM_DES  (NUM_DES),
    .SEL_W    (SEL_W),
    .GUARD_CYC(GUARD_CYC),
    .RST_CYC  (RST_CYC)
  ) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .des_sel     (des_sel),
    .sel_lock    (lock),
    .state       (state),
    .switch_start(switch_start),
    .active_sel  (active_sel),
    .switch_busy (switch_busy),
    .sel_err     (sel_err)
  );

  // io_out is blanked from the cycle a switch is accepted, so it never leaks across the busy window.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out    <= '0;
      des_io_in <= '0;
      des_reset <= '1;
    end else begin
      io_out <= (state == ACTIVE && !switch_start) ? des_io_out[active_sel] : '0;
      for (int i = 0; i < NUM_DES; i++) begin
        if (SEL_W'(i) == active_sel) begin
          unique case (state)
            ACTIVE: begin
              des_io_in[i] <= io_in;
              des_reset[i] <= 1'b0;
            end
            QUIESCE: begin
              des_io_in[i] <= '0;
              des_reset[i] <= 1'b0;
            end
            RESET_NEW: begin
              des_io_in[i] <= '0;
              des_reset[i] <= 1'b1;
            end
            default: begin
              des_io_in[i] <= '0;
              des_reset[i] <= 1'b1;
            end
          endcase
        end else if (hold_if_not_sel) begin
          des_io_in[i] <= '0;
          des_reset[i] <= 1'b1;
        end else begin
          des_io_in[i] <= io_in;
          des_reset[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_design_mux_seq.sv
// Directed self-checking bench for design_mux_seq (NUM_DES=10, GUARD_CYC=4, RST_CYC=8).
module tb_design_mux_seq;

  localparam int NUM_DES = 10;
  localparam int IO_W    = 12;
  localparam int SEL_W   = 4;

  logic                         clock = 1'b0;
  logic                         reset;
  logic [IO_W-1:0]              io_in;
  logic [IO_W-1:0]              io_out;
  logic [SEL_W-1:0]             des_sel;
  logic                         hold;
  logic [NUM_DES-1:0][IO_W-1:0] des_io_in;
  logic [NUM_DES-1:0]           des_reset;
  logic [NUM_DES-1:0][IO_W-1:0] des_io_out;
  logic [SEL_W-1:0]             active_sel;
  logic                         switch_busy;
  logic                         sel_err;
`ifdef MUX_SEL_LOCK_EN
  logic                         sel_lock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  design_mux_seq #(
    .NUM_DES(NUM_DES), .IO_W(IO_W), .SEL_W(SEL_W), .GUARD_CYC(4), .RST_CYC(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in          (io_in),
    .io_out         (io_out),
    .des_sel        (des_sel),
    .hold_if_not_sel(hold),
    .des_io_in      (des_io_in),
    .des_reset      (des_reset),
    .des_io_out     (des_io_out),
    .active_sel     (active_sel),
    .switch_busy    (switch_busy),
    .sel_err        (sel_err)
`ifdef MUX_SEL_LOCK_EN
    ,
    .sel_lock       (sel_lock)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_switch(input logic [SEL_W-1:0] target);
    int n;
    des_sel = target;
    tick();
    n = 0;
    while (switch_busy && n < 40) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (switch_busy !== 1'b0 || active_sel !== target) begin
      errors++;
      $display("[TB] FAIL switch_to_%0d: busy=%b active=%0d required busy=0 active=%0d",
               target, switch_busy, active_sel, target);
    end
  endtask

  task automatic test_reset();
    logic [NUM_DES-1:0][IO_W-1:0] exp_in;
    reset = 1'b1; des_sel = 4'd5; hold = 1'b0; io_in = 12'h055;
    for (int i = 0; i < NUM_DES; i++) des_io_out[i] = 12'h100 + IO_W'(i);
    des_io_out[5] = 12'hA5A;
    tick(); tick();
    checks++;
    if (io_out !== '0 || switch_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out: io_out=%h busy=%b required 000 0", io_out, switch_busy);
    end
    checks++;
    if (des_reset !== '1 || des_io_in !== '0) begin
      errors++;
      $display("[TB] FAIL reset_des: des_reset=%b des_io_in=%h required all-1 all-0", des_reset, des_io_in);
    end
    checks++;
    if (active_sel !== 4'd5) begin
      errors++;
      $display("[TB] FAIL reset_active: got %0d required 5", active_sel);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (io_out !== 12'hA5A || active_sel !== 4'd5 || switch_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release: io_out=%h active=%0d busy=%b required A5A 5 0", io_out, active_sel, switch_busy);
    end
    for (int i = 0; i < NUM_DES; i++) exp_in[i] = 12'h055;
    checks++;
    if (des_io_in !== exp_in || des_reset !== '0) begin
      errors++;
      $display("[TB] FAIL release_des: des_io_in=%h des_reset=%b required all-055 all-0", des_io_in, des_reset);
    end
    des_io_out[5] = 12'h123;
    tick();
    checks++;
    if (io_out !== 12'h123) begin
      errors++;
      $display("[TB] FAIL io_follow: got %h required 123", io_out);
    end
  endtask

  task automatic test_switch();
    int busy_cnt = 0, rst9_cnt = 0, first_rst9 = 0, first_act9 = 0, first_data = 0;
    logic zero_ok = 1'b1, busy_n1 = 1'b0, rst5_q = 1'b1, rst9_mid = 1'b0;
    logic [IO_W-1:0] in5_q = '1, in9_mid = '1;
    hold = 1'b0; io_in = 12'h3C3; des_io_out[9] = 12'h999; des_sel = 4'd9;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (switch_busy) busy_cnt++;
      if (des_reset[9]) begin
        rst9_cnt++;
        if (first_rst9 == 0) first_rst9 = n;
      end
      if (active_sel == 4'd9 && first_act9 == 0) first_act9 = n;
      if (n <= 13 && io_out !== '0) zero_ok = 1'b0;
      if (io_out == 12'h999 && first_data == 0) first_data = n;
      if (n == 1) busy_n1 = switch_busy;
      if (n == 3) begin in5_q = des_io_in[5]; rst5_q = des_reset[5]; end
      if (n == 8) begin in9_mid = des_io_in[9]; rst9_mid = des_reset[9]; end
    end
    checks++;
    if (busy_n1 !== 1'b1 || busy_cnt != 12) begin
      errors++;
      $display("[TB] FAIL busy_window: rise=%b cycles=%0d required 1 12", busy_n1, busy_cnt);
    end
    checks++;
    if (!zero_ok || first_data != 14) begin
      errors++;
      $display("[TB] FAIL io_blank: zero_ok=%b first_data_cycle=%0d required 1 14", zero_ok, first_data);
    end
    checks++;
    if (first_act9 != 5) begin
      errors++;
      $display("[TB] FAIL active_update: cycle=%0d required 5", first_act9);
    end
    checks++;
    if (rst9_cnt != 8 || first_rst9 != 6) begin
      errors++;
      $display("[TB] FAIL new_reset: cycles=%0d start=%0d required 8 6", rst9_cnt, first_rst9);
    end
    checks++;
    if (in5_q !== '0 || rst5_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL quiesce_old: des_io_in=%h des_reset=%b required 000 0", in5_q, rst5_q);
    end
    checks++;
    if (in9_mid !== '0 || rst9_mid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_new_in: des_io_in=%h des_reset=%b required 000 1", in9_mid, rst9_mid);
    end
  endtask

  task automatic test_hold();
    logic [NUM_DES-1:0][IO_W-1:0] exp_in;
    logic [NUM_DES-1:0]           exp_rst;
    do_switch(4'd3);
    hold = 1'b1; io_in = 12'h3C3;
    tick();
    exp_in = '0; exp_in[3] = 12'h3C3;
    exp_rst = '1; exp_rst[3] = 1'b0;
    checks++;
    if (des_io_in !== exp_in || des_reset !== exp_rst) begin
      errors++;
      $display("[TB] FAIL hold_on: des_io_in=%h des_reset=%b required %h %b", des_io_in, des_reset, exp_in, exp_rst);
    end
    hold = 1'b0;
    tick();
    for (int i = 0; i < NUM_DES; i++) exp_in[i] = 12'h3C3;
    checks++;
    if (des_io_in !== exp_in || des_reset !== '0) begin
      errors++;
      $display("[TB] FAIL hold_off: des_io_in=%h des_reset=%b required all-3C3 all-0", des_io_in, des_reset);
    end
  endtask

  task automatic test_invalid();
    des_sel = 4'd10;
    tick();
    checks++;
    if (sel_err !== 1'b1 || switch_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sel_10: sel_err=%b busy=%b required 1 0", sel_err, switch_busy);
    end
    des_sel = 4'd15;
    tick(); tick(); tick();
    checks++;
    if (sel_err !== 1'b1 || switch_busy !== 1'b0 || active_sel !== 4'd3) begin
      errors++;
      $display("[TB] FAIL sel_15: sel_err=%b busy=%b active=%0d required 1 0 3", sel_err, switch_busy, active_sel);
    end
    des_sel = 4'd3;
    tick();
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sel_clear: got %b required 0", sel_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [SEL_W-1:0] act13 = '0, act18 = '0;
    logic busy13 = 1'b1, busy14 = 1'b0;
    do_switch(4'd2);
    des_sel = 4'd4;
    for (int n = 1; n <= 18; n++) begin
      tick();
      if (n == 3) des_sel = 4'd6;
      if (n == 13) begin act13 = active_sel; busy13 = switch_busy; end
      if (n == 14) busy14 = switch_busy;
      if (n == 18) act18 = active_sel;
    end
    checks++;
    if (act13 !== 4'd4 || busy13 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_switch_done: active=%0d busy=%b required 4 0", act13, busy13);
    end
    checks++;
    if (busy14 !== 1'b1 || act18 !== 4'd6) begin
      errors++;
      $display("[TB] FAIL second_switch: busy=%b active=%0d required 1 6", busy14, act18);
    end
    do_switch(4'd6);
  endtask

  task automatic test_reset_mid();
    des_sel = 4'd1;
    tick(); tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (switch_busy !== 1'b0 || active_sel !== 4'd1 || io_out !== '0 || des_reset !== '1) begin
      errors++;
      $display("[TB] FAIL reset_abort: busy=%b active=%0d io_out=%h des_reset=%b required 0 1 000 all-1",
               switch_busy, active_sel, io_out, des_reset);
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (switch_busy !== 1'b0 || active_sel !== 4'd1 || io_out !== des_io_out[1]) begin
      errors++;
      $display("[TB] FAIL after_abort: busy=%b active=%0d io_out=%h required 0 1 101", switch_busy, active_sel, io_out);
    end
  endtask

`ifdef MUX_SEL_LOCK_EN
  task automatic test_lock();
    sel_lock = 1'b1; des_sel = 4'd2;
    tick(); tick(); tick();
    checks++;
    if (switch_busy !== 1'b0 || active_sel !== 4'd1) begin
      errors++;
      $display("[TB] FAIL lock_hold: busy=%b active=%0d required 0 1", switch_busy, active_sel);
    end
    sel_lock = 1'b0;
    tick();
    checks++;
    if (switch_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_release: busy=%b required 1", switch_busy);
    end
  endtask
`endif

  initial begin
`ifdef MUX_SEL_LOCK_EN
    sel_lock = 1'b0;
`endif
    test_reset();
    test_switch();
    test_hold();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
`ifdef MUX_SEL_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
